serial_adder_ctrl: RTL and testbench

- Bit-serial adder controller. One full-adder bit slice, built from two existing half_adder instances plus an OR, is reused over WIDTH cycles to add two WIDTH-bit operands.
- Sequences operand shifting, carry feedback and result assembly.
- Start/ready/done handshake toward the requesting logic.
- Trades area for latency: WIDTH+1 cycles per add.

---
 rtl/serial_adder_ctrl_pkg.sv | 12 +
 rtl/half_adder.sv | 12 +
 rtl/serial_adder_ctrl_full_adder_bit.sv | 19 +
 rtl/serial_adder_ctrl.sv | 100 ++++++++++
 tb/tb_serial_adder_ctrl.sv | 213 +++++++++++++++++++++
 5 files changed

// File: rtl/serial_adder_ctrl_pkg.sv
// Shared definitions for the bit-serial adder controller: FSM encoding and width.
package serial_adder_ctrl_pkg;

    localparam int STATE_W = 2;

    typedef enum logic [STATE_W-1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/half_adder.sv
// Single-bit half adder.
// Latency: combinational.
// Backpressure: none.
module half_adder (
    input  logic a,
    input  logic b,
    output logic s,
    output logic c
);
    assign s = a ^ b;
    assign c = a & b;
endmodule

// File: rtl/serial_adder_ctrl_full_adder_bit.sv
// One full-adder bit slice built from two half adders and an OR.
// Latency: combinational.
// Backpressure: none.
module full_adder_bit (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);
    logic s0;
    logic c0;
    logic c1;

    half_adder u_ha0 (.a(a),  .b(b),  .s(s0), .c(c0));
    half_adder u_ha1 (.a(s0), .b(ci), .s(s),  .c(c1));

    assign co = c0 | c1;
endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder: one full-adder slice reused over WIDTH cycles per add.
// Latency: WIDTH busy cycles after the accepted start, done pulses on the next cycle.
// Backpressure: start is only sampled while ready=1; requests at other times are dropped.
module serial_adder_ctrl
    import serial_adder_ctrl_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);
    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    state_t             state;
    logic [WIDTH-1:0]   op_a;
    logic [WIDTH-1:0]   op_b;
    logic [WIDTH-2:0]   acc;
    logic               carry;
    logic [CNT_W-1:0]   bitcnt;
    logic               bit_s;
    logic               bit_c;
    logic [WIDTH-1:0]   acc_next;

    full_adder_bit u_fa (
        .a  (op_a[0]),
        .b  (op_b[0]),
        .ci (carry),
        .s  (bit_s),
        .co (bit_c)
    );

    // acc holds the WIDTH-1 bits already produced; the new bit enters at the MSB.
    assign acc_next = {bit_s, acc};

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            ready  <= 1'b1;
            busy   <= 1'b0;
            done   <= 1'b0;
            op_a   <= '0;
            op_b   <= '0;
            acc    <= '0;
            carry  <= 1'b0;
            bitcnt <= '0;
            sum    <= '0;
            cout   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        op_a   <= a;
                        op_b   <= b;
                        carry  <= cin;
                        bitcnt <= '0;
                        state  <= RUN;
                        ready  <= 1'b0;
                        busy   <= 1'b1;
                    end
                end
                RUN: begin
                    op_a   <= op_a >> 1;
                    op_b   <= op_b >> 1;
                    acc    <= acc_next[WIDTH-1:1];
                    carry  <= bit_c;
                    bitcnt <= bitcnt + CNT_W'(1);
                    if (bitcnt == LAST_BIT) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        sum   <= acc_next;
                        cout  <= bit_c;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    done  <= 1'b0;
                    ready <= 1'b1;
                end
                default: begin
                    // Unreachable encoding: fall back to a clean idle.
                    state <= IDLE;
                    ready <= 1'b1;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Directed and random checks of serial_adder_ctrl at WIDTH=8 and WIDTH=5.
module tb_serial_adder_ctrl;
    logic       clk = 1'b0;
    logic       rst;
    logic       start8, start5;
    logic [7:0] a8, b8;
    logic [4:0] a5, b5;
    logic       cin8, cin5;
    logic       ready8, busy8, done8, cout8;
    logic       ready5, busy5, done5, cout5;
    logic [7:0] sum8;
    logic [4:0] sum5;

    int total  = 0;
    int passed = 0;
    int dn8    = 0;
    int dn5    = 0;

    always #5 clk = ~clk;

    serial_adder_ctrl #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8), .cin(cin8),
        .ready(ready8), .busy(busy8), .done(done8), .sum(sum8), .cout(cout8)
    );

    serial_adder_ctrl #(.WIDTH(5)) dut5 (
        .clk(clk), .rst(rst), .start(start5), .a(a5), .b(b5), .cin(cin5),
        .ready(ready5), .busy(busy5), .done(done5), .sum(sum5), .cout(cout5)
    );

    always @(negedge clk) begin
        if (done8) dn8++;
        if (done5) dn5++;
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp)
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        else
            passed++;
    endtask

    // Called at a negedge with ready8=1; returns at a negedge with ready8=1.
    task automatic add8(input logic [7:0] ta, input logic [7:0] tb_, input logic tc,
                        input string nm, input bit timing, input bit scramble);
        int n;
        logic [8:0] full;
        full = {1'b0, ta} + {1'b0, tb_} + {8'd0, tc};
        a8 = ta; b8 = tb_; cin8 = tc; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        if (scramble) begin
            a8 = ~ta; b8 = ~tb_; cin8 = ~tc;
        end
        n = 0;
        while (busy8 && n < 100) begin
            n++;
            @(negedge clk);
        end
        if (timing) chk({nm, " busy cycles"}, 64'(n), 64'd8);
        chk({nm, " done"}, 64'(done8), 64'd1);
        chk({nm, " sum"}, 64'(sum8), 64'(full[7:0]));
        chk({nm, " cout"}, 64'(cout8), 64'(full[8]));
        @(negedge clk);
        if (timing) begin
            chk({nm, " ready after done"}, 64'(ready8), 64'd1);
            chk({nm, " done one cycle"}, 64'(done8), 64'd0);
        end
    endtask

    task automatic add5(input logic [4:0] ta, input logic [4:0] tb_, input logic tc,
                        input string nm, input bit timing);
        int n;
        logic [5:0] full;
        full = {1'b0, ta} + {1'b0, tb_} + {5'd0, tc};
        a5 = ta; b5 = tb_; cin5 = tc; start5 = 1'b1;
        @(negedge clk);
        start5 = 1'b0;
        n = 0;
        while (busy5 && n < 100) begin
            n++;
            @(negedge clk);
        end
        if (timing) chk({nm, " busy cycles"}, 64'(n), 64'd5);
        chk({nm, " done"}, 64'(done5), 64'd1);
        chk({nm, " sum"}, 64'(sum5), 64'(full[4:0]));
        chk({nm, " cout"}, 64'(cout5), 64'(full[5]));
        @(negedge clk);
        if (timing) chk({nm, " ready after done"}, 64'(ready5), 64'd1);
    endtask

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       cin;
        logic [7:0] sum;
        logic       cout;
    } vec_t;

    vec_t vecs [8];

    initial begin
        int t_done [$];
        int base8, base5, n_rand;
        logic [8:0] got;

        vecs[0] = '{8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0};
        vecs[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1};
        vecs[2] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1};
        vecs[3] = '{8'h03, 8'h04, 1'b0, 8'h07, 1'b0};
        vecs[4] = '{8'h00, 8'h00, 1'b1, 8'h01, 1'b0};
        vecs[5] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1};
        vecs[6] = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0};
        vecs[7] = '{8'hAA, 8'h55, 1'b1, 8'h00, 1'b1};

        rst = 1'b1; start8 = 1'b0; start5 = 1'b0;
        a8 = '0; b8 = '0; cin8 = 1'b0; a5 = '0; b5 = '0; cin5 = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        chk("reset ready", 64'(ready8), 64'd1);
        chk("reset busy", 64'(busy8), 64'd0);
        chk("reset done", 64'(done8), 64'd0);
        chk("reset sum", 64'(sum8), 64'd0);
        chk("reset cout", 64'(cout8), 64'd0);
        chk("reset w5 ready", 64'(ready5), 64'd1);

        // Table of directed vectors with hand-computed results.
        for (int i = 0; i < 8; i++) begin
            int n;
            a8 = vecs[i].a; b8 = vecs[i].b; cin8 = vecs[i].cin; start8 = 1'b1;
            @(negedge clk);
            start8 = 1'b0;
            n = 0;
            while (busy8 && n < 100) begin
                n++;
                @(negedge clk);
            end
            chk($sformatf("vec%0d busy cycles", i), 64'(n), 64'd8);
            chk($sformatf("vec%0d done", i), 64'(done8), 64'd1);
            chk($sformatf("vec%0d sum", i), 64'(sum8), 64'(vecs[i].sum));
            chk($sformatf("vec%0d cout", i), 64'(cout8), 64'(vecs[i].cout));
            @(negedge clk);
            chk($sformatf("vec%0d ready", i), 64'(ready8), 64'd1);
            chk($sformatf("vec%0d sum held", i), 64'(sum8), 64'(vecs[i].sum));
        end

        // Operands changed right after capture must not disturb the add.
        add8(8'h01, 8'h01, 1'b0, "scramble", 1'b1, 1'b1);

        // start held high: one add every WIDTH+2 cycles.
        a8 = 8'h01; b8 = 8'h01; cin8 = 1'b0; start8 = 1'b1;
        for (int t = 1; t <= 40; t++) begin
            @(negedge clk);
            if (done8) begin
                t_done.push_back(t);
                chk($sformatf("hold sum t%0d", t), 64'(sum8), 64'h02);
            end
        end
        start8 = 1'b0;
        chk("hold done count", 64'(t_done.size()), 64'd4);
        for (int k = 1; k < t_done.size(); k++)
            chk($sformatf("hold spacing %0d", k), 64'(t_done[k] - t_done[k-1]), 64'd10);
        repeat (12) @(negedge clk);

        // Reset in the 4th RUN cycle aborts the add.
        base8 = dn8;
        a8 = 8'h80; b8 = 8'h80; cin8 = 1'b0; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        repeat (3) @(negedge clk);
        chk("abort busy before rst", 64'(busy8), 64'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort ready", 64'(ready8), 64'd1);
        chk("abort busy", 64'(busy8), 64'd0);
        chk("abort sum", 64'(sum8), 64'd0);
        chk("abort cout", 64'(cout8), 64'd0);
        repeat (10) @(negedge clk);
        chk("abort no done", 64'(dn8 - base8), 64'd0);
        add8(8'h03, 8'h04, 1'b0, "after abort", 1'b1, 1'b0);

        // Non-power-of-two width.
        add5(5'h1F, 5'h01, 1'b1, "w5 corner", 1'b1);
        chk("w5 corner exact sum", 64'(sum5), 64'h01);

        // Random regression on both widths.
        base8 = dn8;
        base5 = dn5;
        n_rand = 1000;
        for (int i = 0; i < n_rand; i++) begin
            add8(8'($urandom), 8'($urandom), 1'($urandom), "rand8", 1'b0, 1'b0);
            add5(5'($urandom), 5'($urandom), 1'($urandom), "rand5", 1'b0);
        end
        chk("rand8 done count", 64'(dn8 - base8), 64'(n_rand));
        chk("rand5 done count", 64'(dn5 - base5), 64'(n_rand));

        got = {cout8, sum8};
        chk("final held result width", 64'(got[8:0] >> 9), 64'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
